// File: rtl/cache_ctrl.sv
// Cache write/dump sequencer: fills a byte SRAM from the host, then streams
// it out to the downstream stage when full or on a flush request.
module cache_ctrl #(
    parameter int DEPTH = 255
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       flush,
    input  logic       rd_ready,
    output logic       rd_valid,
    output logic [7:0] cache_addr,
    output logic       cache_wen,
    output logic       cache_ren,
    output logic       cnt_enable,
    output logic       cnt_clear,
    output logic [7:0] rollover_val,
    input  logic [7:0] count_out,
    input  logic       rollover_flag,
    output logic [7:0] fill_level,
    output logic       dump_busy,
    output logic       dump_done
);

    localparam logic [7:0] DEPTH_VAL = 8'(DEPTH);

    typedef enum logic [1:0] {
        INIT,
        FILL,
        DUMP
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] fill_len;
    logic       flush_pend;
    logic       flush_dump;
    logic       start_dump;

    // A pending flush only becomes a dump when there is something to dump.
    assign flush_dump = flush_pend && (count_out != 8'd0);
    assign start_dump = (state == FILL) && (rollover_flag || flush_dump);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            INIT: next_state = FILL;
            FILL: if (start_dump) next_state = DUMP;
            DUMP: if (rollover_flag) next_state = FILL;
            default: next_state = INIT;
        endcase
    end

    // An empty-cache flush is dropped here simply by not being re-armed.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fill_len   <= 8'd0;
            flush_pend <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= cache_ren;
            if (start_dump) begin
                fill_len <= rollover_flag ? DEPTH_VAL : count_out;
            end
            if (state == FILL) begin
                flush_pend <= flush && !start_dump;
            end else begin
                flush_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        wr_ready     = 1'b0;
        cache_addr   = 8'd0;
        cache_wen    = 1'b0;
        cache_ren    = 1'b0;
        cnt_enable   = 1'b0;
        cnt_clear    = 1'b0;
        rollover_val = 8'd0;
        fill_level   = 8'd0;
        dump_busy    = 1'b0;
        dump_done    = 1'b0;
        case (state)
            INIT: begin
                cnt_clear = 1'b1;
            end
            FILL: begin
                rollover_val = DEPTH_VAL;
                fill_level   = count_out;
                cache_addr   = count_out;
                wr_ready     = !rollover_flag && !flush_pend;
                if (start_dump) begin
                    cnt_clear = 1'b1;
                end else if (wr_valid && wr_ready) begin
                    cache_wen  = 1'b1;
                    cnt_enable = 1'b1;
                end
            end
            DUMP: begin
                rollover_val = fill_len;
                dump_busy    = 1'b1;
                cache_addr   = count_out;
                if (rollover_flag) begin
                    cnt_clear = 1'b1;
                    dump_done = 1'b1;
                end else if (rd_ready) begin
                    cache_ren  = 1'b1;
                    cnt_enable = 1'b1;
                end
            end
            default: begin
                cnt_clear = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: a DEPTH=4 instance runs a per-cycle vector table,
// a DEPTH=8 instance runs flush/back-pressure/reset sequences via a scoreboard.
module tb_cache_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst;
    logic wr_valid;
    logic flush;
    logic rd_ready;

    logic       a_wr_ready, a_rd_valid, a_wen, a_ren, a_enable, a_clear;
    logic       a_busy, a_done, a_flag;
    logic [7:0] a_addr, a_rollover, a_fill;
    logic [7:0] a_count = 8'd0;

    logic       b_wr_ready, b_rd_valid, b_wen, b_ren, b_enable, b_clear;
    logic       b_busy, b_done, b_flag;
    logic [7:0] b_addr, b_rollover, b_fill;
    logic [7:0] b_count = 8'd0;

    cache_ctrl #(.DEPTH(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .wr_valid(wr_valid), .wr_ready(a_wr_ready),
        .flush(flush), .rd_ready(rd_ready), .rd_valid(a_rd_valid),
        .cache_addr(a_addr), .cache_wen(a_wen), .cache_ren(a_ren),
        .cnt_enable(a_enable), .cnt_clear(a_clear), .rollover_val(a_rollover),
        .count_out(a_count), .rollover_flag(a_flag), .fill_level(a_fill),
        .dump_busy(a_busy), .dump_done(a_done)
    );

    cache_ctrl #(.DEPTH(8)) dut8 (
        .clk(clk), .n_rst(n_rst), .wr_valid(wr_valid), .wr_ready(b_wr_ready),
        .flush(flush), .rd_ready(rd_ready), .rd_valid(b_rd_valid),
        .cache_addr(b_addr), .cache_wen(b_wen), .cache_ren(b_ren),
        .cnt_enable(b_enable), .cnt_clear(b_clear), .rollover_val(b_rollover),
        .count_out(b_count), .rollover_flag(b_flag), .fill_level(b_fill),
        .dump_busy(b_busy), .dump_done(b_done)
    );

    // External rollover counter models.
    assign a_flag = (a_count == a_rollover);
    assign b_flag = (b_count == b_rollover);

    always @(posedge clk) begin
        if (a_clear) a_count <= 8'd0;
        else if (a_enable) a_count <= (a_count == a_rollover) ? 8'd1 : a_count + 8'd1;
        if (b_clear) b_count <= 8'd0;
        else if (b_enable) b_count <= (b_count == b_rollover) ? 8'd1 : b_count + 8'd1;
    end

    int errors = 0;
    int checks = 0;
    int wr_q[$];
    int rd_q[$];
    int rdv_cnt  = 0;
    int done_cnt = 0;

    typedef struct {
        logic       wv, fl, rr;
        logic       wr_ready, wen, ren, rdv, busy, done, clear;
        logic [7:0] addr, fill;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic wv, input logic fl, input logic rr);
        @(negedge clk);
        wr_valid = wv;
        flush    = fl;
        rd_ready = rr;
        #1;
    endtask

    // One cycle on the DEPTH=8 instance with scoreboard bookkeeping.
    task automatic step8(input logic wv, input logic fl, input logic rr);
        apply_stimulus(wv, fl, rr);
        check("wen_ren_exclusive", int'(b_wen && b_ren), 0);
        check("enable_clear_exclusive", int'(b_enable && b_clear), 0);
        if (b_wen) begin
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL wr_extra: cache_wen at addr %0d, none expected", b_addr);
            end else begin
                check("wr_addr", int'(b_addr), wr_q.pop_front());
            end
        end
        if (b_ren) begin
            check("ren_needs_rd_ready", int'(rr), 1);
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL rd_extra: cache_ren at addr %0d, none expected", b_addr);
            end else begin
                check("rd_addr", int'(b_addr), rd_q.pop_front());
            end
        end
        if (b_rd_valid) rdv_cnt++;
        if (b_done) done_cnt++;
    endtask

    task automatic do_write(input int addr, input logic fl);
        wr_q.push_back(addr);
        step8(1'b1, fl, 1'b0);
    endtask

    task automatic reset_dut();
        #1 n_rst = 1'b0;
        #1;
        wr_q.delete();
        rd_q.delete();
        check("rst_clear", int'(b_clear), 1);
        check("rst_busy", int'(b_busy), 0);
        check("rst_rd_valid", int'(b_rd_valid), 0);
        check("rst_wr_ready", int'(b_wr_ready), 0);
        check("rst_done", int'(b_done), 0);
        @(posedge clk);
        @(posedge clk);
        #2 n_rst = 1'b1;
        step8(1'b0, 1'b0, 1'b0);
        check("init_clear", int'(b_clear), 1);
        check("init_wr_ready", int'(b_wr_ready), 0);
        step8(1'b0, 1'b0, 1'b0);
        check("fill_wr_ready", int'(b_wr_ready), 1);
        check("fill_level0", int'(b_fill), 0);
    endtask

    task automatic finish_dump();
        int d0 = done_cnt;
        for (int k = 0; k < 40 && done_cnt == d0; k++) step8(1'b0, 1'b0, 1'b1);
        check("dump_done_seen", done_cnt - d0, 1);
        check("rd_valid_at_done", int'(b_rd_valid), 1);
        check("rd_q_drained", rd_q.size(), 0);
        step8(1'b0, 1'b0, 1'b0);
        check("post_dump_busy", int'(b_busy), 0);
        check("post_dump_wr_ready", int'(b_wr_ready), 1);
        check("post_dump_fill", int'(b_fill), 0);
    endtask

    task automatic check_output(input int i);
        check($sformatf("v%0d.wr_ready", i), int'(a_wr_ready), int'(vecs[i].wr_ready));
        check($sformatf("v%0d.wen", i), int'(a_wen), int'(vecs[i].wen));
        check($sformatf("v%0d.ren", i), int'(a_ren), int'(vecs[i].ren));
        check($sformatf("v%0d.rd_valid", i), int'(a_rd_valid), int'(vecs[i].rdv));
        check($sformatf("v%0d.busy", i), int'(a_busy), int'(vecs[i].busy));
        check($sformatf("v%0d.done", i), int'(a_done), int'(vecs[i].done));
        check($sformatf("v%0d.clear", i), int'(a_clear), int'(vecs[i].clear));
        check($sformatf("v%0d.fill", i), int'(a_fill), int'(vecs[i].fill));
        if (vecs[i].wen || vecs[i].ren)
            check($sformatf("v%0d.addr", i), int'(a_addr), int'(vecs[i].addr));
    endtask

    initial begin
        int rdv0;
        int d0;
        logic pat[5];

        n_rst    = 1'b0;
        wr_valid = 1'b0;
        flush    = 1'b0;
        rd_ready = 1'b0;

        //           wv fl rr  wrr wen ren rdv bsy dn clr addr fill
        vecs[0]  = '{1, 0, 0,  0,  0,  0,  0,  0,  0, 1,  0,   0};
        vecs[1]  = '{1, 0, 0,  1,  1,  0,  0,  0,  0, 0,  0,   0};
        vecs[2]  = '{1, 0, 0,  1,  1,  0,  0,  0,  0, 0,  1,   1};
        vecs[3]  = '{1, 0, 0,  1,  1,  0,  0,  0,  0, 0,  2,   2};
        vecs[4]  = '{1, 0, 0,  1,  1,  0,  0,  0,  0, 0,  3,   3};
        vecs[5]  = '{1, 0, 0,  0,  0,  0,  0,  0,  0, 1,  0,   4};
        vecs[6]  = '{0, 0, 1,  0,  0,  1,  0,  1,  0, 0,  0,   0};
        vecs[7]  = '{0, 0, 1,  0,  0,  1,  1,  1,  0, 0,  1,   0};
        vecs[8]  = '{0, 0, 1,  0,  0,  1,  1,  1,  0, 0,  2,   0};
        vecs[9]  = '{0, 0, 1,  0,  0,  1,  1,  1,  0, 0,  3,   0};
        vecs[10] = '{0, 0, 1,  0,  0,  0,  1,  1,  1, 1,  0,   0};
        vecs[11] = '{0, 0, 0,  1,  0,  0,  0,  0,  0, 0,  0,   0};

        #3;
        check("a_rst_clear", int'(a_clear), 1);
        check("a_rst_wr_ready", int'(a_wr_ready), 0);
        check("a_rst_rd_valid", int'(a_rd_valid), 0);
        @(posedge clk);
        @(posedge clk);
        #2 n_rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].wv, vecs[i].fl, vecs[i].rr);
            check_output(i);
        end

        // 5 writes then flush; a flush during DUMP must be ignored.
        reset_dut();
        rdv0 = rdv_cnt;
        for (int i = 0; i < 5; i++) do_write(i, 1'b0);
        step8(1'b0, 1'b1, 1'b0);
        check("flush5_not_busy", int'(b_busy), 0);
        step8(1'b0, 1'b0, 1'b0);
        check("flush5_clear", int'(b_clear), 1);
        check("flush5_wr_ready", int'(b_wr_ready), 0);
        for (int i = 0; i < 5; i++) rd_q.push_back(i);
        step8(1'b0, 1'b1, 1'b1);
        check("flush5_busy", int'(b_busy), 1);
        check("flush5_len", int'(b_rollover), 5);
        finish_dump();
        check("flush5_rd_valid_cnt", rdv_cnt - rdv0, 5);

        // 3-byte dump under rd_ready back-pressure.
        reset_dut();
        for (int i = 0; i < 3; i++) do_write(i, 1'b0);
        step8(1'b0, 1'b1, 1'b0);
        step8(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) rd_q.push_back(i);
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) step8(1'b0, 1'b0, pat[i]);
        finish_dump();

        // Empty flush is discarded; flush with write 2 dumps 2 bytes.
        step8(1'b0, 1'b1, 1'b0);
        check("eflush_wr_ready0", int'(b_wr_ready), 1);
        step8(1'b0, 1'b0, 1'b0);
        check("eflush_pend_wr_ready", int'(b_wr_ready), 0);
        check("eflush_busy", int'(b_busy), 0);
        check("eflush_clear", int'(b_clear), 0);
        step8(1'b0, 1'b0, 1'b0);
        check("eflush_wr_ready2", int'(b_wr_ready), 1);
        check("eflush_fill", int'(b_fill), 0);
        rdv0 = rdv_cnt;
        do_write(0, 1'b0);
        do_write(1, 1'b1);
        check("wflush_wr_q", wr_q.size(), 0);
        step8(1'b0, 1'b0, 1'b0);
        check("wflush_clear", int'(b_clear), 1);
        rd_q.push_back(0);
        rd_q.push_back(1);
        step8(1'b0, 1'b0, 1'b1);
        check("wflush_len", int'(b_rollover), 2);
        finish_dump();
        check("wflush_rd_valid_cnt", rdv_cnt - rdv0, 2);

        // Reset in the middle of a dump.
        reset_dut();
        for (int i = 0; i < 5; i++) do_write(i, 1'b0);
        step8(1'b0, 1'b1, 1'b0);
        step8(1'b0, 1'b0, 1'b0);
        rd_q.push_back(0);
        rd_q.push_back(1);
        step8(1'b0, 1'b0, 1'b1);
        step8(1'b0, 1'b0, 1'b1);
        check("mid_busy", int'(b_busy), 1);
        d0 = done_cnt;
        reset_dut();
        check("mid_no_done", done_cnt - d0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
